// File: rtl/vga_line_dma.sv
// vga_line_dma: per-line framebuffer read DMA feeding the VGA pixel FIFO byte by byte
module vga_line_dma #(
  parameter int LINE_BYTES  = 640,
  parameter int FRAME_LINES = 480
) (
  input  logic        CLK_WB,
  input  logic        RST_ASYNC_WB,
  input  logic        CFG_EN_IN,
  input  logic [31:0] CFG_BASE_ADDR_IN,
  input  logic        VS_STB_IN,
  input  logic        HS_STB_IN,
  output logic        WB_CYC_OUT,
  output logic        WB_STB_OUT,
  output logic        WB_WE_OUT,
  output logic [3:0]  WB_SEL_OUT,
  output logic [31:0] WB_ADR_OUT,
  input  logic [31:0] WB_DAT_IN,
  input  logic        WB_ACK_IN,
  output logic        FIFO_DATA_EN_OUT,
  output logic [7:0]  FIFO_DATA_OUT,
  input  logic        FIFO_FULL_IN,
  output logic        LINE_LATE_OUT,
  output logic        BUSY_OUT
);
  localparam logic [10:0] LB = 11'(LINE_BYTES);
  localparam logic [10:0] FL = 11'(FRAME_LINES);
  typedef enum logic [1:0] {IDLE, REQ, PUSH, DONE} state_t;
  state_t      state;
  logic        en, pending, abort;
  logic [31:0] addr, word;
  logic [1:0]  byte_idx;
  logic [10:0] byte_cnt, trig_cnt;
  logic [9:0]  line_cnt;
  logic        hs_trig;
  // trig_cnt counts lines accepted this frame (started or queued), so early HS strobes cannot overrun the frame
  assign hs_trig          = HS_STB_IN && !VS_STB_IN && en && trig_cnt < FL;
  assign FIFO_DATA_EN_OUT = state == PUSH && !FIFO_FULL_IN;
  assign FIFO_DATA_OUT    = state == PUSH ? word[{byte_idx, 3'b000} +: 8] : 8'h00;
  assign BUSY_OUT         = state != IDLE;
  assign WB_WE_OUT        = 1'b0;
  assign WB_SEL_OUT       = 4'hF;
  // line fetch sequencer; a VS strobe overrides everything except an outstanding WB read
  always_ff @(posedge CLK_WB or posedge RST_ASYNC_WB) begin
    if (RST_ASYNC_WB) begin
      state         <= IDLE;
      en            <= 1'b0;
      pending       <= 1'b0;
      abort         <= 1'b0;
      addr          <= '0;
      word          <= '0;
      byte_idx      <= '0;
      byte_cnt      <= '0;
      trig_cnt      <= '0;
      line_cnt      <= '0;
      WB_CYC_OUT    <= 1'b0;
      WB_STB_OUT    <= 1'b0;
      WB_ADR_OUT    <= '0;
      LINE_LATE_OUT <= 1'b0;
    end else begin
      LINE_LATE_OUT <= 1'b0;
      if (hs_trig) begin
        if (state != IDLE && pending) LINE_LATE_OUT <= 1'b1;
        else trig_cnt <= trig_cnt + 11'd1;
        if (state != IDLE) pending <= 1'b1;
      end
      case (state)
        IDLE: begin
          pending <= pending && hs_trig;
          if (pending || hs_trig) begin
            state      <= REQ;
            WB_CYC_OUT <= 1'b1;
            WB_STB_OUT <= 1'b1;
            WB_ADR_OUT <= {addr[31:2], 2'b00};
          end
        end
        REQ: if (WB_ACK_IN) begin
          WB_CYC_OUT <= 1'b0;
          WB_STB_OUT <= 1'b0;
          abort      <= 1'b0;
          if (abort) state <= IDLE;
          else begin
            word     <= WB_DAT_IN;
            addr     <= addr + 32'd4;
            byte_idx <= 2'd0;
            state    <= PUSH;
          end
        end
        PUSH: if (!FIFO_FULL_IN) begin
          byte_idx <= byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            byte_cnt <= byte_cnt + 11'd4;
            if (byte_cnt + 11'd4 == LB) state <= DONE;
            else begin
              state      <= REQ;
              WB_CYC_OUT <= 1'b1;
              WB_STB_OUT <= 1'b1;
              WB_ADR_OUT <= {addr[31:2], 2'b00};
            end
          end
        end
        DONE: begin
          line_cnt <= line_cnt + 10'd1;
          byte_cnt <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (VS_STB_IN) begin
        en            <= CFG_EN_IN;
        addr          <= CFG_BASE_ADDR_IN;
        line_cnt      <= '0;
        byte_cnt      <= '0;
        byte_idx      <= '0;
        trig_cnt      <= 11'(CFG_EN_IN);
        LINE_LATE_OUT <= 1'b0;
        if (state == REQ && !WB_ACK_IN) begin
          abort   <= 1'b1;
          pending <= CFG_EN_IN;
        end else begin
          abort      <= 1'b0;
          pending    <= 1'b0;
          state      <= CFG_EN_IN ? REQ : IDLE;
          WB_CYC_OUT <= CFG_EN_IN;
          WB_STB_OUT <= CFG_EN_IN;
          WB_ADR_OUT <= {CFG_BASE_ADDR_IN[31:2], 2'b00};
        end
      end
    end
  end
endmodule

// File: tb/tb_vga_line_dma.sv
// tb_vga_line_dma: scoreboard bench for the VGA line read DMA
module tb_vga_line_dma;
  logic        clk = 1'b0, rst = 1'b1, cfg_en = 1'b0, vs = 1'b0, hs = 1'b0;
  logic [31:0] cfg_base = '0, dat = '0;
  logic        ack = 1'b0, full = 1'b0;
  logic        cyc, stb, we, fifo_en, late, busy;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [7:0]  fifo_data;
  int          n_cmp = 0, n_err = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] exp_adr = '0, hold_adr = '0, force_adr = '1;
  bit          hold = 1'b0, discard = 1'b0;
  int          push_cnt = 0, late_cnt = 0, cyc_cnt = 0, rd_cnt = 0;

  vga_line_dma #(.LINE_BYTES(640), .FRAME_LINES(3)) dut (
    .CLK_WB(clk), .RST_ASYNC_WB(rst), .CFG_EN_IN(cfg_en), .CFG_BASE_ADDR_IN(cfg_base),
    .VS_STB_IN(vs), .HS_STB_IN(hs), .WB_CYC_OUT(cyc), .WB_STB_OUT(stb), .WB_WE_OUT(we),
    .WB_SEL_OUT(sel), .WB_ADR_OUT(adr), .WB_DAT_IN(dat), .WB_ACK_IN(ack),
    .FIFO_DATA_EN_OUT(fifo_en), .FIFO_DATA_OUT(fifo_data), .FIFO_FULL_IN(full),
    .LINE_LATE_OUT(late), .BUSY_OUT(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a == force_adr) ? 32'h44332211 : a * 32'h9E3779B1 + 32'h0001_2345;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_vs(input logic e, input logic [31:0] base);
    cfg_en = e; cfg_base = base; vs = 1'b1; tick(); vs = 1'b0;
  endtask

  task automatic pulse_hs();
    hs = 1'b1; tick(); hs = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int quiet = 0, n = 0;
    while (quiet < 3 && n < 20000) begin
      @(negedge clk);
      quiet = busy ? 0 : quiet + 1;
      n++;
    end
    chk({tag, "_idle"}, 32'(busy), 0);
    tick();
  endtask

  task automatic wait_cyc_adr(input string tag, input logic [31:0] a);
    int n = 0;
    while (!(cyc && adr == a) && n < 5000) begin @(negedge clk); n++; end
    chk({tag, "_cyc"}, 32'(cyc), 1);
    chk({tag, "_adr"}, adr, a);
  endtask

  // Wishbone slave: one-cycle ACK, expected bytes queued as each read is acknowledged
  initial forever begin
    @(posedge clk); #1;
    if (rst) ack = 1'b0;
    else if (ack) ack = 1'b0;
    else if (cyc && stb && !(hold && adr == hold_adr)) begin
      ack = 1'b1;
      dat = mem(adr);
      if (discard) discard = 1'b0;
      else begin
        chk("wb_adr", adr, exp_adr);
        exp_adr += 4;
        rd_cnt++;
        for (int k = 0; k < 4; k++) exp_q.push_back(dat[8*k +: 8]);
      end
    end
  end

  // FIFO-side monitor: pop and compare every pushed byte
  always @(negedge clk) if (!rst) begin
    if (fifo_en) begin
      logic [7:0] b;
      b = exp_q.size() != 0 ? exp_q.pop_front() : 8'hxx;
      chk("fifo_data", {24'h0, fifo_data}, {24'h0, b});
      chk("en_vs_full", 32'(full), 0);
      push_cnt++;
    end
    if (late) late_cnt++;
    if (cyc) cyc_cnt++;
  end

  initial begin
    int p0, r0, l0, c0, n;
    tick(3);
    chk("rst_cyc", 32'(cyc), 0);
    chk("rst_stb", 32'(stb), 0);
    chk("rst_we", 32'(we), 0);
    chk("rst_sel", 32'(sel), 32'hF);
    chk("rst_adr", adr, 0);
    chk("rst_en", 32'(fifo_en), 0);
    chk("rst_data", 32'(fifo_data), 0);
    chk("rst_late", 32'(late), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    tick();
    // one full line from 0x1000
    exp_adr = 32'h1000; p0 = push_cnt; r0 = rd_cnt;
    pulse_vs(1'b1, 32'h1000);
    chk("t1_busy", 32'(busy), 1);
    wait_idle("t1");
    chk("t1_reads", 32'(rd_cnt - r0), 160);
    chk("t1_pushes", 32'(push_cnt - p0), 640);
    chk("t1_line_cnt", 32'(dut.line_cnt), 1);
    chk("t1_q_empty", 32'(exp_q.size()), 0);
    // FIFO full stall inside word 0x44332211
    force_adr = 32'h1284; p0 = push_cnt; r0 = rd_cnt;
    pulse_hs();
    n = 0;
    while (!(fifo_en && fifo_data == 8'h22 && rd_cnt == r0 + 2) && n < 2000) begin @(negedge clk); n++; end
    chk("t2_saw_22", 32'(fifo_data), 32'h22);
    @(posedge clk); #1;
    full = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("t2_stall_en", 32'(fifo_en), 0);
      chk("t2_hold_data", 32'(fifo_data), 32'h33);
    end
    @(posedge clk); #1;
    full = 1'b0;
    @(negedge clk);
    chk("t2_resume_en", 32'(fifo_en), 1);
    wait_idle("t2");
    chk("t2_pushes", 32'(push_cnt - p0), 640);
    chk("t2_line_cnt", 32'(dut.line_cnt), 2);
    force_adr = '1;
    // two HS during line 0: one queued, one late
    exp_adr = 32'h1000; p0 = push_cnt; r0 = rd_cnt; l0 = late_cnt;
    pulse_vs(1'b1, 32'h1000);
    tick(20);
    pulse_hs();
    tick(20);
    chk("t3_no_late_yet", 32'(late_cnt - l0), 0);
    pulse_hs();
    @(negedge clk);
    chk("t3_late_pulse", 32'(late), 1);
    wait_idle("t3");
    chk("t3_late_once", 32'(late_cnt - l0), 1);
    chk("t3_reads", 32'(rd_cnt - r0), 320);
    chk("t3_pushes", 32'(push_cnt - p0), 1280);
    // VS while a read at 0x1100 is outstanding
    hold_adr = 32'h1100; hold = 1'b1; exp_adr = 32'h1000;
    pulse_vs(1'b1, 32'h1000);
    wait_cyc_adr("t4_stall", 32'h1100);
    tick(2);
    pulse_vs(1'b1, 32'h8002);
    chk("t4_line_cnt", 32'(dut.line_cnt), 0);
    tick(3);
    chk("t4_cyc_held", 32'(cyc), 1);
    chk("t4_stb_held", 32'(stb), 1);
    chk("t4_adr_held", adr, 32'h1100);
    chk("t4_q_empty", 32'(exp_q.size()), 0);
    p0 = push_cnt;
    discard = 1'b1; exp_adr = 32'h8000; hold = 1'b0;
    wait_idle("t4");
    chk("t4_pushes", 32'(push_cnt - p0), 640);
    // frame limit of three lines
    exp_adr = 32'h2000; p0 = push_cnt; l0 = late_cnt;
    pulse_vs(1'b1, 32'h2000);
    wait_idle("t5_l0");
    repeat (2) begin pulse_hs(); wait_idle("t5_ln"); end
    chk("t5_pushes", 32'(push_cnt - p0), 1920);
    c0 = cyc_cnt;
    pulse_hs();
    tick(30);
    chk("t5_extra_ignored", 32'(cyc_cnt - c0), 0);
    chk("t5_no_late", 32'(late_cnt - l0), 0);
    // disabled frame
    c0 = cyc_cnt;
    pulse_vs(1'b0, 32'h3000);
    repeat (3) begin pulse_hs(); tick(50); end
    chk("t6_no_cyc", 32'(cyc_cnt - c0), 0);
    chk("t6_busy", 32'(busy), 0);
    // async reset drops the bus mid-read without a clock edge
    hold_adr = 32'h4000; hold = 1'b1; exp_adr = 32'h4000;
    pulse_vs(1'b1, 32'h4000);
    wait_cyc_adr("t7_stall", 32'h4000);
    #2;
    rst = 1'b1;
    #1;
    chk("t7_cyc", 32'(cyc), 0);
    chk("t7_stb", 32'(stb), 0);
    chk("t7_busy", 32'(busy), 0);
    tick(2);
    rst = 1'b0; hold = 1'b0;
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
